// File: rtl/heartbeat_gen.sv
// heartbeat_gen
//   Keepalive source for the system watchdog. After enable and a short
//   startup hold, hb_out toggles every HB_HALF_PERIOD cycles for as long as
//   firmware keeps kicking. A missed kick window or an external driver fault
//   latches FAULT and freezes hb_out, so the watchdog stops seeing edges.
//   One clk_1khz cycle is 1 ms.
//
// Ports
//   clk_1khz       1 kHz system clock
//   rst_n          asynchronous active-low reset
//   enable         level, requests heartbeat generation
//   kick           firmware keepalive, rising edge only
//   fault_in       level, motor driver fault
//   clear_fault    level, request to leave FAULT
//   hb_out         heartbeat line, every toggle is a valid edge
//   hb_active      1 only in RUN
//   fault_latched  1 only in FAULT
//   fault_code     00 none, 01 external fault, 10 kick timeout
module heartbeat_gen #(
   parameter int HB_HALF_PERIOD = 20,
   parameter int STARTUP_DELAY  = 10,
   parameter int KICK_TIMEOUT   = 100,
   parameter int FAULT_HOLD     = 500
) (
   input  logic       clk_1khz,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       kick,
   input  logic       fault_in,
   input  logic       clear_fault,
   output logic       hb_out,
   output logic       hb_active,
   output logic       fault_latched,
   output logic [1:0] fault_code
);

   localparam int SW = $clog2(STARTUP_DELAY + 1);
   localparam int HW = $clog2(HB_HALF_PERIOD + 1);
   localparam int KW = $clog2(KICK_TIMEOUT + 1);
   localparam int FW = $clog2(FAULT_HOLD + 1);

   localparam logic [SW-1:0] ST_LAST   = SW'(STARTUP_DELAY - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HB_HALF_PERIOD - 1);
   localparam logic [KW-1:0] KICK_LAST = KW'(KICK_TIMEOUT - 1);
   localparam logic [FW-1:0] HOLD_LAST = FW'(FAULT_HOLD - 1);

   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_EXT  = 2'b01;
   localparam logic [1:0] CODE_KICK = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_STARTUP, S_RUN, S_FAULT} state_t;

   state_t          state, state_nxt;
   logic [1:0]      cause;          // fault code to latch if FAULT is entered this cycle
   logic [SW-1:0]   st_cnt;
   logic [HW-1:0]   half_cnt;
   logic [KW-1:0]   kick_cnt;
   logic [FW-1:0]   hold_cnt;
   logic            kick_q;
   logic            kick_edge;
   logic            state_change;
   logic            hb_nxt;
   logic [1:0]      code_nxt;

   assign kick_edge    = kick & ~kick_q;
   assign state_change = (state_nxt != state);

   // State register
   always_ff @(posedge clk_1khz or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state; branch order encodes the priority fault_in > timeout > enable
   always_comb begin
      state_nxt = state;
      cause     = CODE_NONE;
      case (state)
         S_IDLE: begin
            if (enable) state_nxt = S_STARTUP;
         end
         S_STARTUP: begin
            if (fault_in) begin
               state_nxt = S_FAULT;
               cause     = CODE_EXT;
            end else if (!enable)          state_nxt = S_IDLE;
            else if (st_cnt == ST_LAST)    state_nxt = S_RUN;
         end
         S_RUN: begin
            if (fault_in) begin
               state_nxt = S_FAULT;
               cause     = CODE_EXT;
            end else if (kick_cnt == KICK_LAST && !kick_edge) begin
               // a kick landing on the terminal count rescues the window
               state_nxt = S_FAULT;
               cause     = CODE_KICK;
            end else if (!enable) state_nxt = S_IDLE;
         end
         S_FAULT: begin
            if (clear_fault && hold_cnt == HOLD_LAST && !fault_in) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs, decoded from the state being entered
   always_comb begin
      hb_nxt   = hb_out;
      code_nxt = CODE_NONE;
      case (state_nxt)
         S_RUN: begin
            // toggle only while staying in RUN, so the first edge is a full
            // half period after entry and a departing cycle never toggles
            if (state == S_RUN && half_cnt == HALF_LAST) hb_nxt = ~hb_out;
         end
         S_FAULT: begin
            hb_nxt   = hb_out;
            code_nxt = (state == S_FAULT) ? fault_code : cause;
         end
         default: hb_nxt = 1'b0;
      endcase
   end

   // Counters and output registers
   always_ff @(posedge clk_1khz or negedge rst_n) begin
      if (!rst_n) begin
         kick_q        <= 1'b0;
         st_cnt        <= '0;
         half_cnt      <= '0;
         kick_cnt      <= '0;
         hold_cnt      <= '0;
         hb_out        <= 1'b0;
         hb_active     <= 1'b0;
         fault_latched <= 1'b0;
         fault_code    <= CODE_NONE;
      end else begin
         kick_q <= kick;

         if (state_change || state != S_STARTUP) st_cnt <= '0;
         else                                    st_cnt <= st_cnt + 1'b1;

         if (state_change || state != S_RUN || half_cnt == HALF_LAST) half_cnt <= '0;
         else                                                         half_cnt <= half_cnt + 1'b1;

         if (state_change || state != S_RUN || kick_edge) kick_cnt <= '0;
         else                                             kick_cnt <= kick_cnt + 1'b1;

         if (state_change || state != S_FAULT) hold_cnt <= '0;
         else if (hold_cnt != HOLD_LAST)       hold_cnt <= hold_cnt + 1'b1;

         hb_out        <= hb_nxt;
         hb_active     <= (state_nxt == S_RUN);
         fault_latched <= (state_nxt == S_FAULT);
         fault_code    <= code_nxt;
      end
   end

endmodule

// File: doc/heartbeat_gen.md
Name: heartbeat_gen

Overview:
Motor-side keepalive source that drives the toggling heartbeat line monitored by the system watchdog. The controller firmware must kick the block periodically. A missed kick or an external driver fault freezes the heartbeat, so the downstream watchdog sees no edges and asserts shutdown. Runs on the 1 kHz system clock, so one cycle = 1 ms.

Parameters:
HB_HALF_PERIOD, 20, cycles between heartbeat toggles; must be less than the watchdog window of 62 cycles.
STARTUP_DELAY, 10, cycles hb_out is held low after enable before toggling starts.
KICK_TIMEOUT, 100, maximum cycles allowed between kick rising edges while running.
FAULT_HOLD, 500, minimum cycles in FAULT before clear_fault is accepted.

Ports:
clk_1khz  input  1  1 kHz system clock.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  level; 1 requests heartbeat generation.
kick  input  1  firmware keepalive; only the rising edge is used.
fault_in  input  1  level; motor driver fault.
clear_fault  input  1  level; request to leave FAULT.
hb_out  output  1  heartbeat line to the watchdog; every toggle is a valid edge.
hb_active  output  1  1 only in RUN.
fault_latched  output  1  1 only in FAULT.
fault_code  output  2  00 none, 01 external fault, 10 kick timeout.

Behaviour:
- All outputs registered. On rst_n=0, asynchronously:
  - State = IDLE, all counters = 0, kick_q = 0.
  - hb_out = 0, hb_active = 0, fault_latched = 0, fault_code = 00.
- Kick edge: kick_q <= kick each cycle; kick_edge = kick & ~kick_q.
- Counter widths: $clog2(param+1). No counter ever wraps.
  - half_cnt and kick_cnt are cleared on every state entry.
  - hold_cnt saturates at FAULT_HOLD-1.
- Priority within a cycle (highest first): fault_in, kick timeout, enable low, toggle.
- IDLE:
  - hb_out = 0; fault_code is cleared to 00.
  - enable=1 -> STARTUP next cycle.
- STARTUP:
  - hb_out = 0; cnt increments each cycle.
  - fault_in=1 -> FAULT (code 01).
  - else enable=0 -> IDLE.
  - else cnt == STARTUP_DELAY-1 -> RUN.
- RUN:
  - hb_active = 1.
  - half_cnt increments; at HB_HALF_PERIOD-1, hb_out toggles and half_cnt <= 0. First toggle occurs HB_HALF_PERIOD cycles after RUN entry.
  - kick_cnt increments each cycle and is reset to 0 on kick_edge.
  - Kick edge and terminal count in the same cycle: the kick wins, kick_cnt <= 0, no fault.
  - kick_cnt == KICK_TIMEOUT-1 with no kick_edge -> FAULT (code 10).
  - fault_in=1 -> FAULT (code 01). This wins over a simultaneous timeout.
  - enable=0 -> IDLE; hb_out is driven to 0 on the same transition.
- FAULT:
  - hb_out is frozen at its value on entry, so no further edges occur.
  - fault_latched = 1; fault_code holds the first cause.
  - hold_cnt counts up and saturates.
  - clear_fault=1 with hold_cnt == FAULT_HOLD-1 and fault_in=0 -> IDLE. Otherwise clear_fault is ignored.
  - enable has no effect in FAULT.
- Kicks outside RUN are ignored. kick_cnt is held at 0 outside RUN.
- A new fault_in while already in FAULT does not change fault_code or restart hold_cnt.
- Reset asserted mid-operation in any state returns everything to reset values immediately.

Test Plan:
1. Reset release, enable=1, kick edge every 50 cycles:
   - hb_out stays 0 for 10 cycles after STARTUP entry.
   - hb_active=1, then the first toggle 20 cycles later, then a toggle every 20 cycles.
   - fault_latched stays 0 for 2000 cycles.
2. In RUN, stop kicking:
   - FAULT entered exactly 100 cycles after the last kick edge; fault_code=10, fault_latched=1, hb_active=0.
   - hb_out shows no edge for the next 600 cycles.
3. In RUN, 1-cycle fault_in pulse -> FAULT next cycle with fault_code=01.
   - clear_fault held from FAULT cycle 200 to 300 -> ignored.
   - clear_fault at cycle 520 with fault_in=0 -> IDLE, code 00.
   - With enable=1, STARTUP follows.
4. Kick edge in exactly the cycle kick_cnt==99 -> no fault; the next timeout occurs 100 cycles later.
   - fault_in and timeout in the same cycle -> fault_code=01.
5. enable=0 mid-RUN while hb_out=1 -> IDLE next cycle, hb_out=0.
   - Re-enable gives a full 10-cycle startup and a fresh kick window.
6. rst_n pulled low mid-FAULT between clock edges -> all outputs 0 immediately.
   - After release, IDLE; no toggles until enable.
